// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and an optional
// 2-entry skid buffer. Control payload reads as CTRL_RST whenever the stage is empty.
module pipe_stage_reg #(
    parameter int                 DATA_W   = 104,
    parameter int                 CTRL_W   = 6,
    parameter logic [CTRL_W-1:0]  CTRL_RST = '0,
    parameter bit                 SKID     = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]        occ_q, occ_nxt;
    logic [DATA_W-1:0] head_data_q, skid_data_q;
    logic [CTRL_W-1:0] head_ctrl_q, skid_ctrl_q;
    logic              in_ready_q;
    logic              push, pop;
    logic              head_load_in, head_load_skid, skid_load;

    assign out_valid = (occ_q != ST_EMPTY);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;

    // Skid mode reports a registered ready so out_ready never reaches in_ready
    // combinationally; reset forces it low while held.
    assign in_ready  = ~reset & (SKID ? in_ready_q : (~out_valid | out_ready));

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        occ_nxt        = occ_q;
        head_load_in   = 1'b0;
        head_load_skid = 1'b0;
        skid_load      = 1'b0;
        case (occ_q)
            ST_EMPTY: begin
                if (push) begin
                    occ_nxt      = ST_ONE;
                    head_load_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    head_load_in = 1'b1;
                end else if (push && SKID) begin
                    occ_nxt   = ST_TWO;
                    skid_load = 1'b1;
                end else if (pop) begin
                    occ_nxt = ST_EMPTY;
                end
            end
            default: begin
                if (pop) begin
                    occ_nxt        = ST_ONE;
                    head_load_skid = 1'b1;
                end
            end
        endcase
        if (flush) occ_nxt = ST_EMPTY;
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: payload registers are reset too, so out_data reads 0 after reset
        // rather than whatever was left from before.
        if (reset) begin
            occ_q       <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            head_data_q <= '0;
            head_ctrl_q <= CTRL_RST;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            occ_q      <= occ_nxt;
            in_ready_q <= (occ_nxt != ST_TWO);
            if (head_load_in) begin
                head_data_q <= in_data;
                head_ctrl_q <= in_ctrl;
            end else if (head_load_skid) begin
                head_data_q <= skid_data_q;
                head_ctrl_q <= skid_ctrl_q;
            end
            if (skid_load) begin
                skid_data_q <= in_data;
                skid_ctrl_q <= in_ctrl;
            end
        end
    end

    assign out_data  = head_data_q;
    assign out_ctrl  = out_valid ? head_ctrl_q : CTRL_RST;
    assign occupancy = occ_q;

endmodule
